// File: rtl/uart_tx_fifo_param_if.sv
// Valid/ready handshake carrying words into the UART transmitter FIFO.
interface uart_tx_fifo_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with an input FIFO. Frames go out LSB-first:
// start, data, optional parity, one or two stop bits.
module uart_tx_fifo_param #(
  parameter int CLKS_PER_BIT = 100,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uart_tx_fifo_param_if.slave           s,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  if (CLKS_PER_BIT < 2) begin : gBadCpb
    $error("uart_tx_fifo_param: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
    $error("uart_tx_fifo_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : gBadParity
    $error("uart_tx_fifo_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStop
    $error("uart_tx_fifo_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
    $error("uart_tx_fifo_param: FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cycCnt_q, cycCnt_d;
  logic [3:0]           bitIdx_q, bitIdx_d;
  logic [DATA_BITS-1:0] shiftReg_q, shiftReg_d;
  logic                 parity_q, parity_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wrPtr_q, rdPtr_q;
  logic [NW-1:0]        cnt_q, cnt_d;
  logic                 ready_q, tx_q, tx_d, busy_q;
  logic                 push, pop, lastCyc, fifoHasData;
  logic [DATA_BITS-1:0] headWord;

  assign push        = s.s_valid && ready_q;
  assign lastCyc     = (cycCnt_q == CW'(CLKS_PER_BIT - 1));
  assign fifoHasData = (cnt_q != '0);
  assign headWord    = mem_q[rdPtr_q];

  // Pop happens from IDLE or on the final stop cycle so frames run back-to-back.
  always_comb begin
    state_d    = state_q;
    cycCnt_d   = lastCyc ? '0 : cycCnt_q + CW'(1);
    bitIdx_d   = bitIdx_q;
    shiftReg_d = shiftReg_q;
    parity_d   = parity_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        cycCnt_d = '0;
        bitIdx_d = '0;
        if (fifoHasData) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (lastCyc) begin
          state_d  = DATA;
          bitIdx_d = '0;
        end
      end
      DATA: begin
        if (lastCyc) begin
          shiftReg_d = shiftReg_q >> 1;
          if (bitIdx_q == 4'(DATA_BITS - 1)) begin
            bitIdx_d = '0;
            state_d  = (PARITY != 0) ? PAR : STOP;
          end else begin
            bitIdx_d = bitIdx_q + 4'd1;
          end
        end
      end
      PAR: begin
        if (lastCyc) begin
          state_d  = STOP;
          bitIdx_d = '0;
        end
      end
      STOP: begin
        if (lastCyc) begin
          if (bitIdx_q == 4'(STOP_BITS - 1)) begin
            bitIdx_d = '0;
            if (fifoHasData) begin
              pop     = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bitIdx_d = bitIdx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      shiftReg_d = headWord;
      parity_d   = (PARITY == 2) ? ~^headWord : ^headWord;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + NW'(1);
      2'b01:   cnt_d = cnt_q - NW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Line level follows the state one cycle later, giving the two-edge push-to-start latency.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shiftReg_q[0];
      PAR:     tx_d = parity_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cycCnt_q   <= '0;
      bitIdx_q   <= '0;
      shiftReg_q <= '0;
      parity_q   <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycCnt_q   <= cycCnt_d;
      bitIdx_q   <= bitIdx_d;
      shiftReg_q <= shiftReg_d;
      parity_q   <= parity_d;
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      cnt_q      <= cnt_d;
      ready_q    <= (cnt_d != NW'(FIFO_DEPTH));
      tx_q       <= tx_d;
      busy_q     <= (state_q != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= s.s_data;
  end

  assign s.s_ready = ready_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign fifo_cnt  = cnt_q;

endmodule
